// File: rtl/edge_fetch.sv
// edge_fetch: walks the packed edge list in the input buffer SRAM and presents
// (src, dst, weight) records on a valid/ready port. Optional: EDGE_FETCH_SKIP_SELF_EN.
module edge_fetch #(
  parameter logic [9:0] BASE_ADDR = 10'd0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  output logic [9:0] mem_addr,
  input  logic [7:0] mem_data,
  output logic       busy,
  output logic       done,
  output logic       edge_valid,
  input  logic       edge_ready,
  output logic [7:0] edge_src,
  output logic [7:0] edge_dst,
  output logic [7:0] edge_weight,
  output logic [7:0] edge_index,
  output logic       edge_last,
  output logic [2:0] fsm_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LD_CNT = 3'd1,
    LD_SRC = 3'd2,
    LD_DST = 3'd3,
    LD_WT  = 3'd4,
    OUT    = 3'd5,
    DONE   = 3'd6
  } state_t;

  state_t     state;
  logic [7:0] count;

  assign fsm_state = state;

  // Handshake: a record transfers on every rising edge where edge_valid and
  // edge_ready are both high; edge_* outputs hold steady until that edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      count       <= 8'd0;
      mem_addr    <= 10'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      edge_valid  <= 1'b0;
      edge_src    <= 8'd0;
      edge_dst    <= 8'd0;
      edge_weight <= 8'd0;
      edge_index  <= 8'd0;
      edge_last   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mem_addr   <= BASE_ADDR;
            edge_index <= 8'd0;
            edge_last  <= 1'b0;
            busy       <= 1'b1;
            state      <= LD_CNT;
          end
        end
        LD_CNT: begin
          count     <= mem_data;
          edge_last <= (mem_data == 8'd1);
          if (mem_data == 8'd0) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            mem_addr <= mem_addr + 10'd1;
            state    <= LD_SRC;
          end
        end
        LD_SRC: begin
          edge_src <= mem_data;
          mem_addr <= mem_addr + 10'd1;
          state    <= LD_DST;
        end
        LD_DST: begin
          edge_dst <= mem_data;
          mem_addr <= mem_addr + 10'd1;
          state    <= LD_WT;
        end
        LD_WT: begin
          edge_weight <= mem_data;
`ifdef EDGE_FETCH_SKIP_SELF_EN
          // Self-loops never relax anything, so they are dropped here while
          // edge_index keeps counting buffer positions.
          if (edge_src == edge_dst) begin
            if (edge_last) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              mem_addr   <= mem_addr + 10'd1;
              edge_index <= edge_index + 8'd1;
              edge_last  <= (edge_index + 8'd1 == count - 8'd1);
              state      <= LD_SRC;
            end
          end else begin
            edge_valid <= 1'b1;
            state      <= OUT;
          end
`else
          edge_valid <= 1'b1;
          state      <= OUT;
`endif
        end
        OUT: begin
          if (edge_ready) begin
            edge_valid <= 1'b0;
            if (edge_last) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              mem_addr   <= mem_addr + 10'd1;
              edge_index <= edge_index + 8'd1;
              edge_last  <= (edge_index + 8'd1 == count - 8'd1);
              state      <= LD_SRC;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
